// File: rtl/cic_pkg.sv
// Shared constants for the CIC interpolator front end: scheduler state
// encoding, default widths, and the 2-entry buffer occupancy helper.
package cic_pkg;

   localparam int WIN_DEF     = 16;
   localparam int RW_DEF      = 8;
   localparam int FLUSH_N_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } sched_state_t;

   // Occupancy after one cycle of push/pop; callers never push full or pop empty.
   function automatic logic [1:0] cnt_next(input logic [1:0] c,
                                           input logic       push,
                                           input logic       pop);
      return c + {1'b0, push} - {1'b0, pop};
   endfunction

endpackage

// File: rtl/cic_rate_sched_if.sv
// Sample stream into the scheduler and the strobed sample stream out to the CIC.
// master = scheduler side, slave = upstream source / CIC sink side.
interface cic_rate_sched_if
   import cic_pkg::*;
#(
   parameter int Win = WIN_DEF
);
   logic signed [Win-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic signed [Win-1:0] cic_data;
   logic                  cic_val;

   modport master (
      input  s_data, s_valid,
      output s_ready, cic_data, cic_val
   );

   modport slave (
      output s_data, s_valid,
      input  s_ready, cic_data, cic_val
   );
endinterface

// File: rtl/cic_skid_buf.sv
// Two-entry FIFO holding upstream samples until the next strobe slot.
module cic_skid_buf
   import cic_pkg::*;
#(
   parameter int Win = WIN_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic           pop,
   input  logic [Win-1:0] din,
   output logic [Win-1:0] head,
   output logic [1:0]     count
);

   logic [Win-1:0] r_mem [2];
   logic           r_wp;
   logic           r_rp;
   logic [1:0]     r_count;
   logic           w_push;
   logic           w_pop;

   // Guard against misuse so the pointers can never run past each other.
   assign w_push = push && (r_count != 2'd2);
   assign w_pop  = pop  && (r_count != 2'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= din;
            r_wp        <= ~r_wp;
         end
         if (w_pop)
            r_rp <= ~r_rp;
         r_count <= cnt_next(r_count, w_push, w_pop);
      end
   end

   assign head  = r_mem[r_rp];
   assign count = r_count;

endmodule

// File: rtl/cic_rate_sched.sv
// Feeds the CIC interpolator one sample every R clocks, zero-stuffs on underflow
// and flushes the comb delays with zeros at end of stream. CIC_UNDERFLOW_HOLD_EN
// makes RUN-state underflow strobes repeat the last sample instead of zero.
module cic_rate_sched
   import cic_pkg::*;
#(
   parameter int Win     = WIN_DEF,
   parameter int RW      = RW_DEF,
   parameter int FLUSH_N = FLUSH_N_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [RW-1:0]    rate,
   cic_rate_sched_if.master bus,
   output logic             underflow,
   output logic             busy
);

   localparam int FW = $clog2(FLUSH_N) + 1;

   logic [1:0]            r_rst_sync;
   logic                  w_rst_n;

   sched_state_t          r_state;
   logic [RW-1:0]         r_phase;
   logic [RW-1:0]         r_rl;
   logic [FW-1:0]         r_flush_cnt;
   logic signed [Win-1:0] r_cic_data;
   logic                  r_cic_val;
   logic                  r_underflow;
   logic                  r_busy;
   logic                  r_s_ready;

   logic [Win-1:0]        w_head;
   logic [1:0]            w_count;
   logic [1:0]            w_count_nxt;
   logic                  w_active;
   logic                  w_slot;
   logic                  w_wrap;
   logic                  w_push;
   logic                  w_pop;
   logic [RW-1:0]         w_phase_nxt;

   // Assert immediately, release two clocks later so no flop sees a runt release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rst_sync <= 2'b00;
      else      r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_active    = (r_state == RUN) || (r_state == FLUSH);
   assign w_slot      = w_active && (r_phase == '0);
   assign w_wrap      = (r_phase == (r_rl - RW'(1)));
   assign w_phase_nxt = w_wrap ? '0 : (r_phase + RW'(1));
   assign w_push      = bus.s_valid && r_s_ready;
   assign w_pop       = w_slot && (w_count != 2'd0);
   assign w_count_nxt = cnt_next(w_count, w_push, w_pop);

   cic_skid_buf #(.Win(Win)) u_buf (
      .clk   (clk),
      .rst   (w_rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (bus.s_data),
      .head  (w_head),
      .count (w_count)
   );

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= IDLE;
         r_phase     <= '0;
         r_rl        <= '0;
         r_flush_cnt <= '0;
         r_cic_data  <= '0;
         r_cic_val   <= 1'b0;
         r_underflow <= 1'b0;
         r_busy      <= 1'b0;
         r_s_ready   <= 1'b0;
      end else begin
         r_cic_val   <= 1'b0;
         r_underflow <= 1'b0;
         r_s_ready   <= (w_count_nxt < 2'd2);
         unique case (r_state)
            IDLE: begin
               r_busy <= 1'b0;
               if (enable && (w_count != 2'd0)) begin
                  r_state <= RUN;
                  r_rl    <= (rate == '0) ? RW'(1) : rate;
                  r_phase <= '0;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               r_phase <= w_phase_nxt;
               if (w_slot) begin
                  r_cic_val <= 1'b1;
                  if (w_pop) begin
                     r_cic_data <= w_head;
                  end else begin
                     r_underflow <= 1'b1;
`ifdef CIC_UNDERFLOW_HOLD_EN
                     r_cic_data  <= r_cic_data;
`else
                     r_cic_data  <= '0;
`endif
                  end
               end
               // Stop only on a period boundary so strobe spacing never glitches.
               if (!enable && w_wrap) begin
                  r_state   <= FLUSH;
                  r_s_ready <= 1'b0;
               end
            end
            FLUSH: begin
               r_phase   <= w_phase_nxt;
               r_s_ready <= 1'b0;
               if (w_slot) begin
                  r_cic_val <= 1'b1;
                  if (w_pop) begin
                     r_cic_data <= w_head;
                  end else begin
                     r_cic_data <= '0;
                     if (r_flush_cnt == FW'(FLUSH_N - 1)) begin
                        r_state     <= IDLE;
                        r_phase     <= '0;
                        r_flush_cnt <= '0;
                        r_busy      <= 1'b0;
                        r_s_ready   <= (w_count_nxt < 2'd2);
                     end else begin
                        r_flush_cnt <= r_flush_cnt + FW'(1);
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.s_ready  = r_s_ready;
   assign bus.cic_data = r_cic_data;
   assign bus.cic_val  = r_cic_val;
   assign underflow    = r_underflow;
   assign busy         = r_busy;

endmodule

// File: tb/tb_cic_rate_sched.sv
// Scoreboard bench for cic_rate_sched: stimulus queues expected strobes
// (data, underflow, spacing); a negedge monitor pops and compares them.
module tb_cic_rate_sched;

   typedef struct {
      int d;
      bit uf;
      int gap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] rate = 8'd1;
   logic       underflow;
   logic       busy;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_cyc = 0;

   cic_rate_sched_if #(.Win(16)) bus ();

   cic_rate_sched #(.Win(16), .RW(8), .FLUSH_N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .rate      (rate),
      .bus       (bus.master),
      .underflow (underflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic exp_push(input int d, input bit uf, input int gap);
      exp_t e;
      e.d = d; e.uf = uf; e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic exp_zeros(input int gap);
      repeat (4) exp_push(0, 1'b0, gap);
   endtask

   task automatic send(input int v, output int stalls);
      stalls = 0;
      @(negedge clk);
      bus.s_data  = 16'(v);
      bus.s_valid = 1'b1;
      while (!bus.s_ready && stalls < 100) begin
         @(negedge clk);
         stalls++;
      end
      if (!bus.s_ready) chk("send_timeout", 0, 1);
   endtask

   task automatic stop_stream(input bit drop_en);
      @(negedge clk);
      bus.s_valid = 1'b0;
      if (drop_en) enable = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int t = 0;
      while (busy && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_busy_low"}, int'(busy), 0);
      @(negedge clk);
      chk({nm, "_drained"}, sb.size(), 0);
   endtask

   task automatic outs_zero(input string nm);
      chk({nm, "_cic_val"},   int'(bus.cic_val), 0);
      chk({nm, "_cic_data"},  int'(bus.cic_data), 0);
      chk({nm, "_underflow"}, int'(underflow), 0);
      chk({nm, "_busy"},      int'(busy), 0);
      chk({nm, "_s_ready"},   int'(bus.s_ready), 0);
   endtask

   task automatic release_chk(input string nm);
      int t = 0;
      @(negedge clk);
      #2 rst = 1'b1;
      while (!bus.s_ready && t < 6) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_s_ready_up"}, int'(bus.s_ready), 1);
      chk({nm, "_idle_busy"},  int'(busy), 0);
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.cic_val) begin
            if (sb.size() == 0) begin
               chk("stray_strobe_data", int'(bus.cic_data), -99999);
            end else begin
               e = sb.pop_front();
               chk("strobe_data", int'(bus.cic_data), e.d);
               chk("strobe_uf",   int'(underflow), int'(e.uf));
               if (e.gap != 0) chk("strobe_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int tot;
      int t;
      bit seen8;
      bit rdy_in_fl;
      bus.s_data  = '0;
      bus.s_valid = 1'b0;

      // Power-on reset
      #1 rst = 1'b0;
      #2 outs_zero("por");
      release_chk("por");

      // Steady rate 4
      rate = 8'd4; enable = 1'b1;
      exp_push(1, 0, 0); exp_push(2, 0, 4); exp_push(3, 0, 4); exp_push(4, 0, 4);
      exp_zeros(4);
      for (int i = 1; i <= 4; i++) send(i, st);
      stop_stream(1'b1);
      wait_idle("steady");

      // Rate 0 behaves as 1: strobe every clock
      rate = 8'd0; enable = 1'b1;
      for (int i = 0; i < 10; i++) exp_push(10 + i, 0, (i == 0) ? 0 : 1);
      exp_zeros(1);
      tot = 0;
      for (int i = 0; i < 10; i++) begin
         send(10 + i, st);
         if (i >= 3) tot += st;
      end
      chk("rate0_no_stall", tot, 0);
      stop_stream(1'b1);
      wait_idle("rate0");

      // Underflow at rate 3
      rate = 8'd3; enable = 1'b1;
      exp_push(5, 0, 0);
`ifdef CIC_UNDERFLOW_HOLD_EN
      exp_push(5, 1, 3);
`else
      exp_push(0, 1, 3);
`endif
      exp_zeros(3);
      send(5, st);
      stop_stream(1'b0);
      repeat (5) @(negedge clk);
      enable = 1'b0;
      wait_idle("uflow");

      // Flush with 7,8 buffered, rate 2
      rate = 8'd2; enable = 1'b0;
      send(7, st);
      send(8, st);
      stop_stream(1'b0);
      exp_push(7, 0, 0); exp_push(8, 0, 2);
      exp_zeros(2);
      @(negedge clk) enable = 1'b1;
      @(negedge clk) enable = 1'b0;
      seen8 = 1'b0; rdy_in_fl = 1'b0; t = 0;
      while (t < 100) begin
         @(negedge clk);
         t++;
         if (!busy) break;
         if (seen8 && bus.s_ready) rdy_in_fl = 1'b1;
         if (bus.cic_val && bus.cic_data == 16'sd8) seen8 = 1'b1;
      end
      chk("flush_s_ready_low", int'(rdy_in_fl), 0);
      chk("flush_busy_low", int'(busy), 0);
      chk("flush_idle_s_ready", int'(bus.s_ready), 1);
      @(negedge clk);
      chk("flush_drained", sb.size(), 0);

      // Backpressure at rate 8, mid-run rate change ignored
      rate = 8'd8; enable = 1'b1;
      for (int i = 0; i < 6; i++) exp_push(100 + i, 0, (i == 0) ? 0 : 8);
      exp_zeros(8);
      tot = 0;
      for (int i = 0; i < 6; i++) begin
         send(100 + i, st);
         tot += st;
         if (i == 2) rate = 8'd2;
      end
      chk("bp_stalled", int'(tot > 0), 1);
      stop_stream(1'b1);
      wait_idle("bp");

      // Asynchronous reset while strobing in RUN
      rate = 8'd1; enable = 1'b0;
      send(40, st);
      send(41, st);
      stop_stream(1'b0);
      exp_push(40, 0, 0);
      @(negedge clk) enable = 1'b1;
      t = 0;
      while (t < 10) begin
         @(negedge clk);
         t++;
         if (bus.cic_val) break;
      end
      chk("midrun_strobe_seen", int'(bus.cic_val), 1);
      #1 rst = 1'b0;
      #1 outs_zero("midrun_rst");
      enable = 1'b0;
      release_chk("midrun");
      enable = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrun_stays_idle", int'(busy), 0);
      enable = 1'b0;

      repeat (5) @(negedge clk);
      chk("final_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
